// File: rtl/sopc_apb_pkg.sv
// sopc_apb_pkg: shared encodings and sizes for the PicoRV32 APB bridge.
// Imported by the bridge and available to APB peripherals in the SoC.
package sopc_apb_pkg;

    // Each slave owns a 4 KB window; PADDR carries the word address in it.
    localparam int APB_WIN_BITS = 12;

    // Slave index is a 4-bit field just above the window offset.
    localparam int APB_MAX_NSLV = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/picorv32_apb_bridge.sv
// picorv32_apb_bridge: PicoRV32 native bus to APB master with per-slave
// PSEL decode, PREADY timeout, bus error flag and APBACTIVE clock hint.
module picorv32_apb_bridge
    import sopc_apb_pkg::*;
#(
    parameter int          NSLV     = 4,
    parameter logic [31:0] APB_BASE = 32'h4000_0000,
    parameter int          TIMEOUT  = 256
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 mem_valid,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic                 mem_ready,
    output logic [31:0]          mem_rdata,
    output logic [NSLV-1:0]      PSEL,
    output logic [9:0]           PADDR,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    input  logic [NSLV*32-1:0]   PRDATA,
    input  logic [NSLV-1:0]      PREADY,
    input  logic [NSLV-1:0]      PSLVERR,
    output logic                 APBACTIVE,
    output logic                 bus_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST =
        (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    apb_state_e      state_q, state_d;
    logic [NSLV-1:0] psel_q, psel_d;
    logic [9:0]      paddr_q, paddr_d;
    logic            pwrite_q, pwrite_d;
    logic [31:0]     pwdata_q, pwdata_d;
    logic            penable_q, penable_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            active_q, active_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            hit;
    logic [3:0]      req_idx;
    logic            idx_ok;
    logic [NSLV-1:0] req_sel;
    logic [31:0]     sel_rdata;
    logic            sel_ready;
    logic            sel_err;
    logic            to_hit;
    logic            unused_addr;

    assign hit     = mem_valid && (mem_addr[31:16] == APB_BASE[31:16]);
    assign req_idx = mem_addr[APB_WIN_BITS+3:APB_WIN_BITS];
    assign idx_ok  = {28'd0, req_idx} < 32'(NSLV);

    // Byte offset inside a word never reaches the APB side.
    assign unused_addr = ^mem_addr[1:0];

    // One-hot select for the requested slave index.
    always_comb begin
        req_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            req_sel[i] = (req_idx == 4'(i));
        end
    end

    // Return path muxed by the held PSEL, so no index decode is needed.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (psel_q[i]) begin
                sel_rdata = PRDATA[i*32 +: 32];
            end
        end
    end

    assign sel_ready = |(PREADY & psel_q);
    assign sel_err   = |(PSLVERR & psel_q);
    assign to_hit    = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Transfer sequencing, address/data latching and completion status.
    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        penable_d = penable_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    if (idx_ok) begin
                        state_d  = ST_SETUP;
                        psel_d   = req_sel;
                        paddr_d  = mem_addr[APB_WIN_BITS-1:2];
                        pwrite_d = |mem_wstrb;
                        pwdata_d = (|mem_wstrb) ? mem_wdata : 32'h0;
                        cnt_d    = '0;
                    end else begin
                        state_d = ST_RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    state_d   = ST_RESP;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    rdata_d   = pwrite_q ? 32'h0 : sel_rdata;
                    err_d     = sel_err;
                end else if (to_hit) begin
                    state_d   = ST_RESP;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
        endcase
        active_d = (state_d != ST_IDLE);
    end

    // State and bus registers; reset clears every output at once.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            psel_q    <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            penable_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            active_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            penable_q <= penable_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mem_ready = (state_q == ST_RESP);
    assign mem_rdata = rdata_q;
    assign bus_err   = err_q;
    assign PSEL      = psel_q;
    assign PADDR     = paddr_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign APBACTIVE = active_q;

endmodule

// File: tb/tb_picorv32_apb_bridge.sv
// tb_picorv32_apb_bridge: randomized and directed bench for the APB bridge
// with behavioural APB slaves and a transaction-level reference model.
module tb_picorv32_apb_bridge;

    localparam int NS = 4;
    localparam int TO = 16;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic              mem_valid = 1'b0;
    logic [31:0]       mem_addr = '0;
    logic [31:0]       mem_wdata = '0;
    logic [3:0]        mem_wstrb = '0;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [NS-1:0]     PSEL;
    logic [9:0]        PADDR;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [NS*32-1:0]  PRDATA;
    logic [NS-1:0]     PREADY;
    logic [NS-1:0]     PSLVERR;
    logic              APBACTIVE;
    logic              bus_err;

    int n_checks = 0;
    int n_fail = 0;

    logic [NS-1:0] stuck = '0;
    logic [NS-1:0] err_cfg = '0;
    int            wait_cfg [NS] = '{default: 0};
    int            wcnt [NS] = '{default: 0};
    logic [31:0]   smem [NS*1024] = '{default: 32'h0};
    logic [31:0]   shadow [int];

    always #5 PCLK = ~PCLK;

    picorv32_apb_bridge #(
        .NSLV(NS),
        .APB_BASE(32'h4000_0000),
        .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .mem_valid(mem_valid),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .PSEL(PSEL),
        .PADDR(PADDR),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR),
        .APBACTIVE(APBACTIVE),
        .bus_err(bus_err)
    );

    // Behavioural APB slaves: configurable wait states, stuck and error.
    always @(posedge PCLK) begin
        for (int i = 0; i < NS; i++) begin
            if (PSEL[i] && PENABLE) begin
                if (PREADY[i]) begin
                    if (PWRITE) smem[i*1024 + int'(PADDR)] <= PWDATA;
                    wcnt[i] <= 0;
                end else begin
                    wcnt[i] <= wcnt[i] + 1;
                end
            end else begin
                wcnt[i] <= 0;
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        PREADY = '0;
        PSLVERR = '0;
        for (int i = 0; i < NS; i++) begin
            PRDATA[i*32 +: 32] = smem[i*1024 + int'(PADDR)];
            PREADY[i] = PSEL[i] && PENABLE && !stuck[i] && (wcnt[i] >= wait_cfg[i]);
            PSLVERR[i] = err_cfg[i];
        end
    end

    // Reference: latency in cycles after the sampling edge (-1 = never),
    // read data and error flag, from the address map and slave settings.
    function automatic void model(input logic [31:0] a, input logic [3:0] s,
                                  output int lat, output logic [31:0] rd, output logic be);
        int idx;
        idx = int'(a[15:12]);
        lat = -1;
        rd = 32'h0;
        be = 1'b0;
        if (a[31:16] != 16'h4000) return;
        if (idx >= NS) begin
            lat = 1;
            be = 1'b1;
            return;
        end
        if (stuck[idx]) begin
            lat = 2 + TO;
            be = 1'b1;
            return;
        end
        lat = 3 + wait_cfg[idx];
        be = err_cfg[idx];
        if (s == 4'h0) rd = shadow.exists(int'(a[15:2])) ? shadow[int'(a[15:2])] : 32'h0;
    endfunction

    function automatic void commit(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int idx;
        idx = int'(a[15:12]);
        if (a[31:16] == 16'h4000 && idx < NS && s != 4'h0 && !stuck[idx])
            shadow[int'(a[15:2])] = d;
    endfunction

    // Issue one request starting at a negedge; returns observed completion
    // and the number of cycles where the APB side looked wrong.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int budget, output int lat, output logic [31:0] rd,
                          output logic be, output int bad);
        logic [NS-1:0] ep;
        logic got;
        ep = '0;
        if (a[31:16] == 16'h4000 && int'(a[15:12]) < NS) ep = NS'(1) << a[15:12];
        mem_addr = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_valid = 1'b1;
        lat = 0;
        rd = 32'h0;
        be = 1'b0;
        bad = 0;
        got = 1'b0;
        while (!got && lat < budget) begin
            @(posedge PCLK);
            lat++;
            @(negedge PCLK);
            if (mem_ready === 1'b1) begin
                got = 1'b1;
                rd = mem_rdata;
                be = bus_err;
                if (PSEL !== '0 || PENABLE !== 1'b0) bad++;
                if (ep != '0 && APBACTIVE !== 1'b1) bad++;
            end else begin
                if (bus_err !== 1'b0) bad++;
                if (ep == '0) begin
                    if (PSEL !== '0 || APBACTIVE !== 1'b0) bad++;
                end else if (PSEL !== ep || PADDR !== a[11:2] || PWRITE !== (s != 4'h0)
                             || PWDATA !== ((s != 4'h0) ? d : 32'h0)
                             || PENABLE !== (lat >= 2) || APBACTIVE !== 1'b1) begin
                    bad++;
                end
            end
        end
        mem_valid = 1'b0;
        if (!got) lat = -1;
        @(posedge PCLK);
        @(negedge PCLK);
        if (mem_ready !== 1'b0 || APBACTIVE !== 1'b0) bad++;
    endtask

    task automatic test_reset();
        int busy;
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        n_checks++;
        if ({PSEL, PADDR, PENABLE, PWRITE, PWDATA, mem_ready, mem_rdata, APBACTIVE, bus_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got psel=%h paddr=%h pen=%b pwr=%b pwdata=%h rdy=%b rdata=%h act=%b err=%b want all 0",
                     PSEL, PADDR, PENABLE, PWRITE, PWDATA, mem_ready, mem_rdata, APBACTIVE, bus_err);
        end
        PRESETn = 1'b1;
        busy = 0;
        repeat (3) begin
            @(negedge PCLK);
            if (APBACTIVE !== 1'b0 || mem_ready !== 1'b0 || PSEL !== '0) busy++;
        end
        n_checks++;
        if (busy != 0) begin
            n_fail++;
            $display("FAIL reset_idle: got %0d busy cycles want 0", busy);
        end
    endtask

    task automatic test_write_basic();
        int lat, elat, bad;
        logic [31:0] rd, erd;
        logic be, ebe;
        wait_cfg[0] = 0;
        model(32'h4000_0008, 4'hF, elat, erd, ebe);
        do_req(32'h4000_0008, 32'h64, 4'hF, 20, lat, rd, be, bad);
        commit(32'h4000_0008, 4'hF, 32'h64);
        n_checks++;
        if (lat !== elat) begin n_fail++; $display("FAIL wr_latency: got %0d want %0d", lat, elat); end
        n_checks++;
        if (be !== ebe || rd !== erd) begin n_fail++; $display("FAIL wr_status: got err=%b rd=%h want err=%b rd=%h", be, rd, ebe, erd); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL wr_bus: got %0d bad cycles want 0", bad); end
        n_checks++;
        if (smem[2] !== 32'h64) begin n_fail++; $display("FAIL wr_slave_data: got %h want %h", smem[2], 32'h64); end
    endtask

    task automatic test_read_wait();
        int lat, elat, bad;
        logic [31:0] rd, erd;
        logic be, ebe;
        wait_cfg[1] = 0;
        do_req(32'h4000_1004, 32'hA5A5_0001, 4'hF, 20, lat, rd, be, bad);
        commit(32'h4000_1004, 4'hF, 32'hA5A5_0001);
        wait_cfg[1] = 3;
        model(32'h4000_1004, 4'h0, elat, erd, ebe);
        do_req(32'h4000_1004, 32'h0, 4'h0, 20, lat, rd, be, bad);
        n_checks++;
        if (lat !== elat) begin n_fail++; $display("FAIL rd_wait_latency: got %0d want %0d", lat, elat); end
        n_checks++;
        if (rd !== erd || rd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rd_wait_data: got %h want %h", rd, erd); end
        n_checks++;
        if (be !== ebe || bad !== 0) begin n_fail++; $display("FAIL rd_wait_bus: got err=%b bad=%0d want err=%b bad=0", be, bad, ebe); end
        wait_cfg[1] = 0;
    endtask

    task automatic test_decode();
        int lat, elat, bad;
        logic [31:0] rd, erd;
        logic be, ebe;
        model(32'h4000_F000, 4'h0, elat, erd, ebe);
        do_req(32'h4000_F000, 32'h0, 4'h0, 10, lat, rd, be, bad);
        n_checks++;
        if (lat !== elat) begin n_fail++; $display("FAIL decerr_latency: got %0d want %0d", lat, elat); end
        n_checks++;
        if (rd !== erd || be !== ebe || bad !== 0) begin
            n_fail++;
            $display("FAIL decerr_status: got rd=%h err=%b bad=%0d want rd=%h err=%b bad=0", rd, be, bad, erd, ebe);
        end
        model(32'h5000_0000, 4'hF, elat, erd, ebe);
        do_req(32'h5000_0000, 32'h1111_2222, 4'hF, 10, lat, rd, be, bad);
        n_checks++;
        if (lat !== elat || bad !== 0) begin n_fail++; $display("FAIL miss_ignored: got lat=%0d bad=%0d want lat=%0d bad=0", lat, bad, elat); end
    endtask

    task automatic test_timeout();
        int lat, elat, bad;
        logic [31:0] rd, erd, d;
        logic be, ebe;
        stuck[3] = 1'b1;
        model(32'h4000_3008, 4'h0, elat, erd, ebe);
        do_req(32'h4000_3008, 32'h0, 4'h0, 40, lat, rd, be, bad);
        n_checks++;
        if (lat !== elat) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", lat, elat); end
        n_checks++;
        if (rd !== erd || be !== ebe || bad !== 0) begin
            n_fail++;
            $display("FAIL timeout_status: got rd=%h err=%b bad=%0d want rd=%h err=%b bad=0", rd, be, bad, erd, ebe);
        end
        stuck[3] = 1'b0;
        wait_cfg[3] = 1;
        d = $urandom;
        do_req(32'h4000_300C, d, 4'hF, 20, lat, rd, be, bad);
        commit(32'h4000_300C, 4'hF, d);
        model(32'h4000_300C, 4'h0, elat, erd, ebe);
        do_req(32'h4000_300C, 32'h0, 4'h0, 20, lat, rd, be, bad);
        n_checks++;
        if (lat !== elat || rd !== erd || be !== ebe || bad !== 0) begin
            n_fail++;
            $display("FAIL after_timeout: got lat=%0d rd=%h err=%b bad=%0d want lat=%0d rd=%h err=%b", lat, rd, be, bad, elat, erd, ebe);
        end
        wait_cfg[3] = 0;
    endtask

    task automatic test_slverr();
        int lat, elat, bad;
        logic [31:0] rd, erd;
        logic be, ebe;
        err_cfg = '0;
        do_req(32'h4000_2000, 32'h1234, 4'hF, 20, lat, rd, be, bad);
        commit(32'h4000_2000, 4'hF, 32'h1234);
        err_cfg[2] = 1'b1;
        model(32'h4000_2000, 4'h0, elat, erd, ebe);
        do_req(32'h4000_2000, 32'h0, 4'h0, 20, lat, rd, be, bad);
        n_checks++;
        if (rd !== erd || rd !== 32'h1234) begin n_fail++; $display("FAIL slverr_data: got %h want %h", rd, erd); end
        n_checks++;
        if (be !== ebe || lat !== elat || bad !== 0) begin
            n_fail++;
            $display("FAIL slverr_flag: got err=%b lat=%0d bad=%0d want err=%b lat=%0d", be, lat, bad, ebe, elat);
        end
        err_cfg = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] va, rd;
        logic got;
        int setup_at, ready_at;
        wait_cfg[0] = 0;
        va = $urandom;
        mem_addr = 32'h4000_0024;
        mem_wdata = va;
        mem_wstrb = 4'hF;
        mem_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            got = mem_ready;
        end
        commit(32'h4000_0024, 4'hF, va);
        mem_wstrb = 4'h0;
        mem_wdata = 32'h0;
        setup_at = -1;
        ready_at = -1;
        rd = 32'h0;
        for (int k = 1; k <= 20 && ready_at < 0; k++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            if (setup_at < 0 && PSEL != '0) setup_at = k;
            if (mem_ready === 1'b1) begin
                ready_at = k;
                rd = mem_rdata;
            end
        end
        mem_valid = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        n_checks++;
        if (got !== 1'b1 || setup_at != 2) begin n_fail++; $display("FAIL b2b_setup: got first=%b setup_at=%0d want 1 and 2", got, setup_at); end
        n_checks++;
        if (ready_at != 4 || rd !== shadow[int'(14'h0009)]) begin
            n_fail++;
            $display("FAIL b2b_read: got ready_at=%0d rd=%h want 4 and %h", ready_at, rd, va);
        end
    endtask

    task automatic test_random();
        int lat, elat, bad, errs;
        logic [31:0] a, d, rd, erd;
        logic [3:0] s;
        logic be, ebe;
        int sl, w;
        errs = 0;
        for (int t = 0; t < 80; t++) begin
            sl = $urandom_range(0, 5);
            w = $urandom_range(0, 7) * 31;
            a = {16'h4000, 4'(sl), 2'b00, 8'(w), 2'b00};
            if ($urandom_range(0, 11) == 0) a[31:16] = 16'h5000;
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            d = $urandom;
            if (sl < NS) begin
                wait_cfg[sl] = $urandom_range(0, 4);
                err_cfg[sl] = ($urandom_range(0, 7) == 0);
                stuck[sl] = ($urandom_range(0, 19) == 0);
            end
            model(a, s, elat, erd, ebe);
            do_req(a, d, s, 40, lat, rd, be, bad);
            commit(a, s, d);
            n_checks++;
            if (lat !== elat || rd !== erd || be !== ebe || bad !== 0) begin
                n_fail++;
                errs++;
                $display("FAIL rand_%0d a=%h s=%h: got lat=%0d rd=%h err=%b bad=%0d want lat=%0d rd=%h err=%b",
                         t, a, s, lat, rd, be, bad, elat, erd, ebe);
            end
            stuck = '0;
            err_cfg = '0;
        end
        for (int i = 0; i < NS; i++) wait_cfg[i] = 0;
    endtask

    task automatic test_reset_mid();
        int lat, elat, bad, rdy;
        logic [31:0] rd, erd;
        logic be, ebe;
        wait_cfg[0] = 10;
        mem_addr = 32'h4000_0010;
        mem_wdata = 32'hDEAD_BEEF;
        mem_wstrb = 4'hF;
        mem_valid = 1'b1;
        repeat (3) @(posedge PCLK);
        #2;
        n_checks++;
        if (PENABLE !== 1'b1 || PSEL !== 4'b0001) begin n_fail++; $display("FAIL pre_reset_access: got pen=%b psel=%b want 1 0001", PENABLE, PSEL); end
        PRESETn = 1'b0;
        #1;
        n_checks++;
        if ({PSEL, PADDR, PENABLE, PWRITE, PWDATA, mem_ready, mem_rdata, APBACTIVE, bus_err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got psel=%h paddr=%h pen=%b pwr=%b pwdata=%h act=%b want all 0",
                     PSEL, PADDR, PENABLE, PWRITE, PWDATA, APBACTIVE);
        end
        mem_valid = 1'b0;
        rdy = 0;
        repeat (2) begin
            @(negedge PCLK);
            if (mem_ready !== 1'b0) rdy++;
        end
        PRESETn = 1'b1;
        repeat (6) begin
            @(negedge PCLK);
            if (mem_ready !== 1'b0 || APBACTIVE !== 1'b0) rdy++;
        end
        n_checks++;
        if (rdy != 0) begin n_fail++; $display("FAIL reset_no_ready: got %0d ready/active cycles want 0", rdy); end
        wait_cfg[0] = 0;
        model(32'h4000_0010, 4'h0, elat, erd, ebe);
        do_req(32'h4000_0010, 32'h0, 4'h0, 20, lat, rd, be, bad);
        n_checks++;
        if (rd !== erd) begin n_fail++; $display("FAIL aborted_write_kept_out: got %h want %h", rd, erd); end
        model(32'h4000_0010, 4'h3, elat, erd, ebe);
        do_req(32'h4000_0010, 32'h0BAD_F00D, 4'h3, 20, lat, rd, be, bad);
        commit(32'h4000_0010, 4'h3, 32'h0BAD_F00D);
        n_checks++;
        if (lat !== elat || lat !== 3 || be !== ebe || bad !== 0) begin
            n_fail++;
            $display("FAIL post_reset_write: got lat=%0d err=%b bad=%0d want lat=%0d err=%b", lat, be, bad, elat, ebe);
        end
        n_checks++;
        if (smem[4] !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL post_reset_slave: got %h want %h", smem[4], 32'h0BAD_F00D); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_decode();
        test_timeout();
        test_slverr();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
